// File: rtl/bram_arb.sv
// Two-port arbiter for a shared backup-RAM bus: CPU side and save/load engine.
// Fixed-latency accesses, CPU priority bounded by a starvation counter.
module bram_arb #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cart_en,
  input  logic        c_req,
  input  logic        c_we_lo,
  input  logic        c_we_hi,
  input  logic [17:0] c_addr,
  input  logic [15:0] c_din,
  output logic        c_ack,
  output logic [15:0] c_dout,
  input  logic        s_req,
  input  logic        s_we,
  input  logic [17:0] s_addr,
  input  logic [15:0] s_din,
  output logic        s_ack,
  output logic [15:0] s_dout,
  output logic [17:0] mem_addr,
  output logic [15:0] mem_dati,
  input  logic [15:0] mem_dato,
  output logic        mem_oe,
  output logic        mem_we_lo,
  output logic        mem_we_hi,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, CPU_ACC, SYS_ACC, CPU_NOP, ACK} state_t;

  localparam logic [2:0] LAT_LAST   = 3'(MEM_LAT - 1);
  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);

  state_t      state_q;
  logic [2:0]  cnt_q;
  logic [2:0]  starve_q;
  logic        rd_q;
  logic        c_ack_q, s_ack_q, busy_q;
  logic        mem_oe_q, mem_we_lo_q, mem_we_hi_q;
  logic [17:0] mem_addr_q;
  logic [15:0] mem_dati_q, c_dout_q, s_dout_q;

  logic       pick_cpu_d, pick_sys_d, c_rd_d;
  logic [2:0] starve_d;

  always_comb begin
    c_rd_d     = !(c_we_lo || c_we_hi);
    pick_cpu_d = c_req && !(s_req && (starve_q == STARVE_LIM));
    pick_sys_d = s_req && !pick_cpu_d;
    starve_d   = 3'd0;
    // Only a CPU win over a waiting sys request counts toward starvation.
    if (pick_cpu_d && s_req)
      starve_d = (starve_q < STARVE_LIM) ? starve_q + 3'd1 : STARVE_LIM;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 3'd0;
      starve_q    <= 3'd0;
      rd_q        <= 1'b0;
      c_ack_q     <= 1'b0;
      s_ack_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_oe_q    <= 1'b0;
      mem_we_lo_q <= 1'b0;
      mem_we_hi_q <= 1'b0;
      mem_addr_q  <= 18'd0;
      mem_dati_q  <= 16'd0;
      c_dout_q    <= 16'd0;
      s_dout_q    <= 16'd0;
    end else begin
      c_ack_q <= 1'b0;
      s_ack_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pick_cpu_d) begin
            cnt_q    <= LAT_LAST;
            starve_q <= starve_d;
            rd_q     <= c_rd_d;
            busy_q   <= 1'b1;
            if (cart_en) begin
              state_q     <= CPU_ACC;
              mem_addr_q  <= c_addr;
              mem_dati_q  <= c_din;
              mem_oe_q    <= c_rd_d;
              mem_we_lo_q <= c_we_lo;
              mem_we_hi_q <= c_we_hi;
            end else begin
              state_q <= CPU_NOP;
            end
          end else if (pick_sys_d) begin
            state_q     <= SYS_ACC;
            cnt_q       <= LAT_LAST;
            starve_q    <= 3'd0;
            rd_q        <= !s_we;
            busy_q      <= 1'b1;
            mem_addr_q  <= s_addr;
            mem_dati_q  <= s_din;
            mem_oe_q    <= !s_we;
            mem_we_lo_q <= s_we;
            mem_we_hi_q <= s_we;
          end
        end
        CPU_ACC, SYS_ACC, CPU_NOP: begin
          if (cnt_q == 3'd0) begin
            state_q     <= ACK;
            mem_oe_q    <= 1'b0;
            mem_we_lo_q <= 1'b0;
            mem_we_hi_q <= 1'b0;
            if (state_q == SYS_ACC) begin
              s_ack_q <= 1'b1;
              if (rd_q) s_dout_q <= mem_dato;
            end else begin
              c_ack_q <= 1'b1;
              // With no cartridge present, reads float high.
              if (rd_q) c_dout_q <= (state_q == CPU_ACC) ? mem_dato : 16'hFFFF;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        ACK: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign c_ack     = c_ack_q;
  assign s_ack     = s_ack_q;
  assign c_dout    = c_dout_q;
  assign s_dout    = s_dout_q;
  assign mem_addr  = mem_addr_q;
  assign mem_dati  = mem_dati_q;
  assign mem_oe    = mem_oe_q;
  assign mem_we_lo = mem_we_lo_q;
  assign mem_we_hi = mem_we_hi_q;
  assign busy      = busy_q;

endmodule
